fir_tap_scheduler: RTL and testbench
====================================

# fir_tap_scheduler

Sequencing controller for the FIR input tap delay lines (stride-1/2/4 variants, binary and SC widths). Accepts input samples over a valid/ready handshake and issues one shift enable per sample to the delay line. Tracks delay-line fill. Once every tap holds a real sample, it holds the line frozen for one stochastic-computing evaluation window of `SC_LEN` cycles and signals frame completion to the downstream accumulator.

## Interface
Parameters:
- `W`, default 8: sample width. Set to `` `n `` for binary lines, `` `n-2 `` for SC lines.
- `TAPS`, default 39: number of taps on the driven delay line.
- `STRIDE`, default 1: tap spacing in samples. Legal values are 1, 2, 4.
- `SC_LEN`, default 256: SC evaluation window in cycles. Must be a power of two, ≥2.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of fill and state.
- `in_data`  in  W  sample to push.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  scheduler can accept.
- `shift_en`  out  1  one-cycle shift strobe to the delay line.
- `shift_data`  out  W  registered sample to load at tap 0.
- `fill`  out  clog2(FILL_MAX+1)  samples currently in the line, saturating.
- `sc_run`  out  1  SC window active; delay line frozen.
- `sc_idx`  out  clog2(SC_LEN)  cycle index within the window.
- `frame_done`  out  1  one-cycle pulse at window end.
- `frame_cnt`  out  16  completed frames (see Configuration).

## Operation
- `FILL_MAX = (TAPS-1)*STRIDE + 1`. Defaults give 39. With `STRIDE=4` it is 153.
- FSM states: IDLE, SHIFT, RUN, DONE.
- IDLE: `in_ready=1`. When `in_valid&in_ready`, register `in_data` into `shift_data` and go to SHIFT.
- SHIFT: `shift_en=1` and `fill <= min(fill+1, FILL_MAX)`.
  - If the post-increment `fill == FILL_MAX`, go to RUN with `sc_idx=0`.
  - Otherwise go to IDLE.
- RUN: `sc_run=1`; `sc_idx` increments each cycle. At `sc_idx==SC_LEN-1`, go to DONE. `sc_idx` wraps to 0.
- DONE: `frame_done=1` for one cycle, then go to IDLE.
- `fill` saturates at `FILL_MAX`. Once full, every later sample triggers a window.
- `shift_data` holds its last value outside SHIFT.
- `flush` has priority over everything except `reset`. Next state is IDLE, `fill=0`, `sc_idx=0`.
  - A flush during RUN aborts the window with no `frame_done`.
  - A flush in the same cycle as a handshake drops the sample: no SHIFT follows.
- Reset values: state IDLE, `in_ready=1`, `shift_en=0`, `shift_data=0`, `fill=0`, `sc_run=0`, `sc_idx=0`, `frame_done=0`, `frame_cnt=0`.
- Reset mid-RUN clears asynchronously; no `frame_done` is emitted.
- `in_ready` is a pure decode of state IDLE, with no combinational path from `in_valid`.

## Timing
- Handshake at edge k: `shift_en=1` during cycle k+1. `fill` updates at edge k+1.
- Line not full: next accept is possible at edge k+2, giving a throughput of 1 sample per 2 cycles.
- Line full after SHIFT:
  - `sc_run` is high for cycles k+2 … k+1+SC_LEN.
  - `frame_done` is high in cycle k+2+SC_LEN.
  - `in_ready` returns in cycle k+3+SC_LEN.
  - Steady-state period is SC_LEN+3 cycles per sample.
- `shift_en` and `sc_run` are never high in the same cycle.

## Configuration
- `FIR_SCHED_STATS_EN` defined:
  - `frame_cnt` increments on each `frame_done` and wraps from 0xFFFF to 0.
  - `flush` does not clear it; only `reset` does.
- Undefined: `frame_cnt` is tied to 0 and no counter flops are inferred.

## Test plan
- **Reset then fill:** reset, then offer 38 samples (1..38) back-to-back with default parameters.
  - Required: 38 `shift_en` pulses spaced 2 cycles, `fill=38`, `sc_run` never asserted.
- **First window:** sample 39.
  - Required: `shift_en` in k+1, `sc_run` over 256 cycles with `sc_idx` 0..255, `frame_done` in k+258, `in_ready` high in k+259.
- **Stride 4:** `STRIDE=4`, `SC_LEN=4`.
  - Required: first `sc_run` only after the 153rd sample; sample 154 produces a window 7 cycles long from handshake to `in_ready`.
- **Flush mid-window:** assert `flush` at `sc_idx=100`.
  - Required: no `frame_done`, `fill=0`, IDLE next cycle; 39 further samples are needed before the next window.
- **Backpressure:** hold `in_valid=1` during RUN.
  - Required: `in_ready=0` throughout and no `shift_en`; the held sample is accepted exactly once, in the cycle after DONE.
- **Stats macro:** with `FIR_SCHED_STATS_EN`, run 3 windows, then flush.
  - Required: `frame_cnt=3` after the flush.
  - Without the macro, `frame_cnt` stays 0.

Source files
------------

// File: rtl/fir_tap_scheduler.sv
// Tap delay-line sequencer: one shift strobe per accepted sample, then an SC_LEN-cycle frozen window once the line is full.
// Optional frame statistics counter enabled by defining FIR_SCHED_STATS_EN.
module fir_tap_scheduler #(
  parameter int unsigned W      = 8,
  parameter int unsigned TAPS   = 39,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned SC_LEN = 256,
  localparam int unsigned FILL_MAX = (TAPS - 1) * STRIDE + 1,
  localparam int unsigned FILL_W   = $clog2(FILL_MAX + 1),
  localparam int unsigned IDX_W    = $clog2(SC_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [W-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              shift_en,
  output logic [W-1:0]      shift_data,
  output logic [FILL_W-1:0] fill,
  output logic              sc_run,
  output logic [IDX_W-1:0]  sc_idx,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, RUN, DONE} state_t;

  localparam logic [FILL_W-1:0] FILL_TOP = FILL_W'(FILL_MAX);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SC_LEN - 1);

  state_t            state;
  logic [FILL_W-1:0] fill_inc;
  logic              idx_last;
  logic              window_end;

  // Saturating fill increment; reaching the top means every tap holds a real sample.
  always_comb begin
    fill_inc = fill + FILL_W'(1);
    if (fill >= FILL_TOP) fill_inc = FILL_TOP;
  end

  assign idx_last   = (sc_idx == IDX_LAST);
  assign window_end = (state == RUN) && idx_last && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      shift_en   <= 1'b0;
      shift_data <= '0;
      fill       <= '0;
      sc_run     <= 1'b0;
      sc_idx     <= '0;
      frame_done <= 1'b0;
    end else if (flush) begin
      // Flush drops any same-cycle handshake and aborts an open window silently.
      state      <= IDLE;
      in_ready   <= 1'b1;
      shift_en   <= 1'b0;
      fill       <= '0;
      sc_run     <= 1'b0;
      sc_idx     <= '0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shift_data <= in_data;
            shift_en   <= 1'b1;
            in_ready   <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shift_en <= 1'b0;
          fill     <= fill_inc;
          if (fill_inc == FILL_TOP) begin
            sc_run <= 1'b1;
            sc_idx <= '0;
            state  <= RUN;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        RUN: begin
          if (idx_last) begin
            sc_run     <= 1'b0;
            sc_idx     <= '0;
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            sc_idx <= sc_idx + IDX_W'(1);
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          in_ready   <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          shift_en   <= 1'b0;
          sc_run     <= 1'b0;
          frame_done <= 1'b0;
          in_ready   <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef FIR_SCHED_STATS_EN
  // Completed-frame counter; survives flush, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (window_end) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler: default line (39 taps, SC_LEN 256) and a stride-4 / SC_LEN-4 line.
module tb_fir_tap_scheduler;

`ifdef FIR_SCHED_STATS_EN
  localparam int unsigned STATS_AFTER3 = 3;
`else
  localparam int unsigned STATS_AFTER3 = 0;
`endif

  logic        clock;
  logic        reset;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        shift_en;
  logic [7:0]  shift_data;
  logic [5:0]  fill;
  logic        sc_run;
  logic [7:0]  sc_idx;
  logic        frame_done;
  logic [15:0] frame_cnt;

  logic        flush4;
  logic [7:0]  data4;
  logic        valid4;
  logic        ready4;
  logic        shift4;
  logic [7:0]  sdata4;
  logic [7:0]  fill4;
  logic        run4;
  logic [1:0]  idx4;
  logic        done4;
  logic [15:0] cnt4;

  int n_checks = 0;
  int n_errors = 0;
  int sh_cnt = 0, run_cnt = 0, fd_cnt = 0, ovl_cnt = 0, busy_rdy_cnt = 0;
  int sh4_cnt = 0, run4_cnt = 0, done4_cnt = 0;

  fir_tap_scheduler dut (
    .clock(clock), .reset(reset), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .shift_en(shift_en), .shift_data(shift_data), .fill(fill),
    .sc_run(sc_run), .sc_idx(sc_idx), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  fir_tap_scheduler #(.W(8), .TAPS(39), .STRIDE(4), .SC_LEN(4)) dut4 (
    .clock(clock), .reset(reset), .flush(flush4), .in_data(data4), .in_valid(valid4),
    .in_ready(ready4), .shift_en(shift4), .shift_data(sdata4), .fill(fill4),
    .sc_run(run4), .sc_idx(idx4), .frame_done(done4), .frame_cnt(cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (shift_en) sh_cnt++;
    if (sc_run) run_cnt++;
    if (frame_done) fd_cnt++;
    if (shift_en && sc_run) ovl_cnt++;
    if (in_ready && (sc_run || frame_done)) busy_rdy_cnt++;
    if (shift4) sh4_cnt++;
    if (run4) run4_cnt++;
    if (done4) done4_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 2000) begin tick(); n++; end
  endtask

  task automatic wait_ready4(output int n);
    n = 0;
    while (!ready4 && n < 2000) begin tick(); n++; end
  endtask

  // Offer v, handshake on the first edge with in_ready, return in cycle k+1.
  task automatic push(input logic [7:0] v, output int waited);
    in_data  = v;
    in_valid = 1'b1;
    wait_ready(waited);
    check("push_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("push_strobe", 32'({shift_en, shift_data}), 32'({1'b1, v}));
  endtask

  task automatic push4(input logic [7:0] v, output int waited);
    data4  = v;
    valid4 = 1'b1;
    wait_ready4(waited);
    check("push4_ready", 32'(ready4), 32'd1);
    tick();
    valid4 = 1'b0;
    check("push4_strobe", 32'({shift4, sdata4}), 32'({1'b1, v}));
  endtask

  initial begin
    int w, wsum, bad, snap, snap2, n;
    reset = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0;
    flush4 = 1'b0; data4 = '0; valid4 = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_outputs", 32'({shift_en, sc_run, frame_done}), 32'd0);
    check("rst_shift_data", 32'(shift_data), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_sc_idx", 32'(sc_idx), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Samples 1..38 back-to-back: after the first, each waits exactly one cycle (2-cycle spacing).
    wsum = 0;
    for (int i = 1; i <= 38; i++) begin
      push(8'(i), w);
      if (i > 1) wsum += w;
    end
    check("fill_gap_sum", 32'(wsum), 32'd37);
    tick();
    check("fill_38", 32'(fill), 32'd38);
    check("fill_shift_cnt", 32'(sh_cnt), 32'd38);
    check("fill_no_run", 32'(run_cnt), 32'd0);
    check("fill_ready", 32'(in_ready), 32'd1);

    // Sample 39 opens the first window.
    push(8'd39, w);
    check("w1_no_run_in_shift", 32'(sc_run), 32'd0);
    tick();
    check("w1_run_start", 32'({sc_run, in_ready}), 32'({1'b1, 1'b0}));
    check("w1_fill_full", 32'(fill), 32'd39);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (sc_run !== 1'b1 || sc_idx !== 8'(i)) bad++;
      tick();
    end
    check("w1_idx_sweep", 32'(bad), 32'd0);
    check("w1_done_pulse", 32'({frame_done, sc_run, in_ready}), 32'({1'b1, 1'b0, 1'b0}));
    check("w1_idx_wrap", 32'(sc_idx), 32'd0);
    tick();
    check("w1_ready_back", 32'({in_ready, frame_done}), 32'({1'b1, 1'b0}));
    check("w1_done_cnt", 32'(fd_cnt), 32'd1);
    check("w1_run_cycles", 32'(run_cnt), 32'd256);

    // Backpressure: hold in_valid high through the whole window.
    snap = sh_cnt;
    push(8'h55, w);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    wait_ready(n);
    check("bp_ready_wait", 32'(n), 32'd258);
    tick();
    in_valid = 1'b0;
    check("bp_held_strobe", 32'({shift_en, shift_data}), 32'({1'b1, 8'hAA}));
    tick();
    check("bp_shift_once", 32'(sh_cnt - snap), 32'd2);
    check("bp_ready_low_busy", 32'(busy_rdy_cnt), 32'd0);
    wait_ready(n);
    check("bp_second_window", 32'(n), 32'd257);
    check("bp_done_cnt", 32'(fd_cnt), 32'd3);
    check("no_overlap", 32'(ovl_cnt), 32'd0);

    // Flush at sc_idx 100 aborts the window.
    push(8'd1, w);
    n = 0;
    while (sc_idx !== 8'd100 && n < 400) begin tick(); n++; end
    check("fl_reach_idx100", 32'({sc_run, sc_idx}), 32'({1'b1, 8'd100}));
    snap = fd_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_idle", 32'({in_ready, sc_run, frame_done}), 32'({1'b1, 1'b0, 1'b0}));
    check("fl_fill", 32'(fill), 32'd0);
    check("fl_idx", 32'(sc_idx), 32'd0);
    check("stats_after_flush", 32'(frame_cnt), 32'(STATS_AFTER3));
    repeat (300) tick();
    check("fl_no_done", 32'(fd_cnt - snap), 32'd0);

    // Flush coincident with a handshake drops the sample.
    in_data = 8'h77; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flhs_no_shift", 32'({shift_en, in_ready}), 32'({1'b0, 1'b1}));
    tick();
    check("flhs_fill", 32'(fill), 32'd0);
    check("flhs_data_hold", 32'(shift_data), 32'd1);

    // Refill: 39 fresh samples needed before the next window.
    snap2 = run_cnt;
    for (int i = 1; i <= 38; i++) push(8'(i + 100), w);
    tick();
    check("refill_no_run", 32'(run_cnt - snap2), 32'd0);
    check("refill_fill", 32'(fill), 32'd38);
    push(8'd200, w);
    tick();
    check("refill_run", 32'(sc_run), 32'd1);
    wait_ready(n);
    check("refill_done", 32'(fd_cnt - snap), 32'd1);

    // Asynchronous reset in the middle of a window.
    push(8'd9, w);
    repeat (50) tick();
    snap = fd_cnt;
    reset = 1'b1;
    #1;
    check("arst_clear", 32'({sc_run, in_ready, frame_done}), 32'({1'b0, 1'b1, 1'b0}));
    check("arst_fill", 32'(fill), 32'd0);
    check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    tick();
    reset = 1'b0;
    repeat (300) tick();
    check("arst_no_done", 32'(fd_cnt - snap), 32'd0);

    // Stride 4, SC_LEN 4: FILL_MAX = 153.
    for (int i = 1; i <= 152; i++) push4(8'(i), w);
    tick();
    check("s4_fill_152", 32'(fill4), 32'd152);
    check("s4_no_run", 32'(run4_cnt), 32'd0);
    push4(8'd153, w);
    tick();
    check("s4_run_after_153", 32'({run4, idx4}), 32'({1'b1, 2'd0}));
    wait_ready4(n);
    push4(8'd154, w);
    wait_ready4(n);
    check("s4_window_len", 32'(n), 32'd6);
    check("s4_run_cycles", 32'(run4_cnt), 32'd8);
    check("s4_done_cnt", 32'(done4_cnt), 32'd2);
    check("s4_fill_sat", 32'(fill4), 32'd153);
    check("s4_shift_cnt", 32'(sh4_cnt), 32'd154);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
